// File: rtl/fb_bht_pkg.sv
// Shared constants and decode helpers for the BHT next-PC predictor.
package fb_bht_pkg;

   // Major opcodes recognised by the predictor
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Bit positions inside the one-hot {beq,bne,blt,bge,bltu,bgeu} vector
   localparam int BC_BEQ  = 5;
   localparam int BC_BNE  = 4;
   localparam int BC_BLT  = 3;
   localparam int BC_BGE  = 2;
   localparam int BC_BLTU = 1;
   localparam int BC_BGEU = 0;

   // Jalr lock FSM states
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   typedef enum logic [1:0] {
      INST_OTHER  = 2'd0,
      INST_JAL    = 2'd1,
      INST_JALR   = 2'd2,
      INST_BRANCH = 2'd3
   } inst_kind_t;

   // Classify a fetched instruction by its opcode
   function automatic inst_kind_t classify(input logic [6:0] opcode);
      inst_kind_t k;
      case (opcode)
         OPC_JAL:    k = INST_JAL;
         OPC_JALR:   k = INST_JALR;
         OPC_BRANCH: k = INST_BRANCH;
         default:    k = INST_OTHER;
      endcase
      return k;
   endfunction

   // B-type immediate, 13 bits including the implicit zero LSB
   function automatic logic [12:0] b_imm_raw(input logic [31:0] inst);
      return {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

   // J-type immediate, 21 bits including the implicit zero LSB
   function automatic logic [20:0] j_imm_raw(input logic [31:0] inst);
      return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

   // One-hot branch-condition decode of funct3; unused encodings give 0
   function automatic logic [5:0] bra_decode(input logic [2:0] funct3);
      logic [5:0] bc;
      bc = '0;
      case (funct3)
         3'b000:  bc[BC_BEQ]  = 1'b1;
         3'b001:  bc[BC_BNE]  = 1'b1;
         3'b100:  bc[BC_BLT]  = 1'b1;
         3'b101:  bc[BC_BGE]  = 1'b1;
         3'b110:  bc[BC_BLTU] = 1'b1;
         3'b111:  bc[BC_BGEU] = 1'b1;
         default: bc = '0;
      endcase
      return bc;
   endfunction

endpackage

// File: rtl/fb_bht_predictor_bank.sv
// Saturating-counter table with per-entry valid bits.
// One combinational read port (zero-latency prediction) and one training write port.
module fb_sat_counter_bank
   import fb_bht_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int CNT_W = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic [CNT_W-1:0]         rd_cnt,
   output logic                     rd_valid,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_idx,
   input  logic                     wr_taken
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((1 << (CNT_W - 1)) - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_reg   [DEPTH];
   logic             valid_reg [DEPTH];
   logic [CNT_W-1:0] wr_cur;
   logic [CNT_W-1:0] wr_next;

   // Reads see the stored value; a same-cycle write is not bypassed
   assign rd_cnt   = cnt_reg[rd_idx];
   assign rd_valid = valid_reg[rd_idx];
   assign wr_cur   = cnt_reg[wr_idx];

   // Saturating step of the entry being trained
   always_comb begin
      wr_next = wr_cur;
      if (wr_taken) begin
         if (wr_cur != CNT_MAX) wr_next = wr_cur + CNT_W'(1);
      end else begin
         if (wr_cur != '0) wr_next = wr_cur - CNT_W'(1);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         // Per-entry state: reset to weak not-taken/invalid, train on write hit
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_reg[gi]   <= CNT_RST;
               valid_reg[gi] <= 1'b0;
            end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
               cnt_reg[gi]   <= wr_next;
               valid_reg[gi] <= 1'b1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/fb_bht_predictor.sv
// IF-phase next-PC unit: PC-indexed saturating-counter branch prediction,
// jal/jalr target generation, EX/MEM branch resolve with redirect/flush,
// table training and branch/mispredict performance counters.
module fb_bht_predictor
   import fb_bht_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 64,
   parameter int CNT_W     = 2,
   parameter int PERF_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   pc,
   input  logic [31:0]       inst,
   input  logic              jalr_en,
   input  logic [XLEN-1:0]   jalr_imm,
   input  logic [XLEN-1:0]   rs1_data,
   input  logic              branch,
   input  logic [XLEN-1:0]   bra_pc,
   input  logic [XLEN-1:0]   bra_imm,
   input  logic              bra_pred_taken,
   input  logic [5:0]        i_bra_control,
   input  logic              NF,
   input  logic              ZF,
   input  logic              CF,
   input  logic              VF,
   output logic              pc_src,
   output logic [XLEN-1:0]   predict_pc,
   output logic              o_pred_taken,
   output logic [5:0]        o_bra_control,
   output logic              lock,
   output logic              address_src,
   output logic [XLEN-1:0]   predict_err_pc,
   output logic              register_rst,
   output logic [PERF_W-1:0] perf_br_cnt,
   output logic [PERF_W-1:0] perf_mis_cnt
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   inst_kind_t      kind;
   logic            is_jal;
   logic            is_jalr;
   logic            is_branch;
   logic [12:0]     b_raw;
   logic [20:0]     j_raw;
   logic [XLEN-1:0] b_imm;
   logic [XLEN-1:0] j_imm;
   logic [XLEN-1:0] jalr_sum;
   logic [CNT_W-1:0] rd_cnt;
   logic            rd_valid;
   logic            pred_taken;
   logic            actual;
   logic            mispredict;
   logic [0:0]      state_reg;
   logic [0:0]      state_next;
   logic            lock_next;

   // ---------------- fetch decode ----------------
   assign kind      = classify(inst[6:0]);
   assign is_jal    = (kind == INST_JAL);
   assign is_jalr   = (kind == INST_JALR);
   assign is_branch = (kind == INST_BRANCH);

   assign b_raw = b_imm_raw(inst);
   assign j_raw = j_imm_raw(inst);
   assign b_imm = {{(XLEN-13){b_raw[12]}}, b_raw};
   assign j_imm = {{(XLEN-21){j_raw[20]}}, j_raw};

   assign jalr_sum = rs1_data + jalr_imm;

   assign o_bra_control = is_branch ? bra_decode(inst[14:12]) : 6'b000000;

   // ---------------- counter table ----------------
   fb_sat_counter_bank #(
      .DEPTH (BHT_DEPTH),
      .CNT_W (CNT_W)
   ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (pc[IDX_W-1:0]),
      .rd_cnt   (rd_cnt),
      .rd_valid (rd_valid),
      .wr_en    (branch),
      .wr_idx   (bra_pc[IDX_W-1:0]),
      .wr_taken (actual)
   );

   // Direction: trained counter when the entry is valid, else backward-taken fallback
   always_comb begin
      pred_taken = 1'b0;
      if (is_branch) begin
         pred_taken = rd_valid ? rd_cnt[CNT_W-1] : b_imm[XLEN-1];
      end
   end

   assign o_pred_taken = pred_taken;

   // Next-PC target; jalr operands take priority once they are valid
   always_comb begin
      predict_pc = '0;
      if (jalr_en) begin
         predict_pc = {jalr_sum[XLEN-1:1], 1'b0};
      end else if (is_jal) begin
         predict_pc = pc + j_imm;
      end else if (is_branch) begin
         predict_pc = pred_taken ? (pc + b_imm) : (pc + XLEN'(1));
      end
   end

   // ---------------- EX/MEM resolve ----------------
   assign actual = (i_bra_control[BC_BEQ]  &  ZF)
                 | (i_bra_control[BC_BNE]  & ~ZF)
                 | (i_bra_control[BC_BLT]  &  (NF ^ VF))
                 | (i_bra_control[BC_BGE]  & ~(NF ^ VF))
                 | (i_bra_control[BC_BLTU] & ~CF)
                 | (i_bra_control[BC_BGEU] &  CF);

   assign mispredict     = branch & (actual != bra_pred_taken);
   assign address_src    = mispredict;
   assign register_rst   = mispredict;
   assign predict_err_pc = actual ? (bra_pc + bra_imm) : (bra_pc + XLEN'(1));

   assign pc_src = is_jal | is_branch | jalr_en | mispredict;

   // ---------------- jalr lock FSM ----------------
   // A flush discards the jalr in IF, so it neither locks nor keeps waiting
   always_comb begin
      state_next = state_reg;
      lock_next  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (is_jalr && !jalr_en && !mispredict) begin
               lock_next  = 1'b1;
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (jalr_en || mispredict) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign lock = lock_next;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   // ---------------- performance counters ----------------
   // Count every resolved branch and every mispredict; both wrap naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_br_cnt  <= '0;
         perf_mis_cnt <= '0;
      end else if (branch) begin
         perf_br_cnt <= perf_br_cnt + PERF_W'(1);
         if (mispredict) perf_mis_cnt <= perf_mis_cnt + PERF_W'(1);
      end
   end

endmodule
